// File: rtl/spike_window_monitor_if.sv
// ---------------------------------------------------------------------------
// spike_window_monitor_if
// Bundles the neuron-side inputs, window configuration and the byte readout of
// spike_window_monitor.
//   enable    : run statistics collection while high
//   spike     : neuron spike bit, sampled every cycle
//   u_in      : signed membrane potential (U_WIDTH bits)
//   win_len   : window spans win_len+1 cycles, captured on entry to RUN
//   rd_next   : single-cycle pulse, consumer has taken the current byte
//   out_valid : a report is held and readable
//   out_sel   : index (0..3) of the byte presented on out_byte
//   out_byte  : selected report byte
// master = producer/consumer side (testbench), slave = the monitor itself.
// ---------------------------------------------------------------------------
interface spike_window_monitor_if #(
    parameter int U_WIDTH   = 6,
    parameter int WIN_WIDTH = 8
);
    logic                        enable;
    logic                        spike;
    logic signed [U_WIDTH-1:0]   u_in;
    logic [WIN_WIDTH-1:0]        win_len;
    logic                        rd_next;
    logic                        out_valid;
    logic [1:0]                  out_sel;
    logic [7:0]                  out_byte;

    modport master (
        output enable, spike, u_in, win_len, rd_next,
        input  out_valid, out_sel, out_byte
    );

    modport slave (
        input  enable, spike, u_in, win_len, rd_next,
        output out_valid, out_sel, out_byte
    );
endinterface

// File: rtl/spike_window_monitor.sv
// ---------------------------------------------------------------------------
// spike_window_monitor
// Collects per-window statistics of a LIF neuron (spike count, last
// inter-spike interval, peak membrane potential), snapshots them at the end of
// each window and serves the snapshot as a 4-byte report through a
// pulse-advanced byte readout.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : spike_window_monitor_if.slave (inputs enable/spike/u_in/win_len/
//           rd_next, outputs out_valid/out_sel/out_byte)
// Report bytes: 0 = spike count, 1 = last ISI, 2 = peak (sign-extended),
//               3 = {overrun, window index}.
// ---------------------------------------------------------------------------
module spike_window_monitor #(
    parameter int U_WIDTH   = 6,
    parameter int WIN_WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    spike_window_monitor_if.slave bus
);
    localparam logic signed [U_WIDTH-1:0] PEAK_MIN = {1'b1, {(U_WIDTH-1){1'b0}}};

    typedef enum logic {C_IDLE, C_RUN}   coll_state_t;
    typedef enum logic {R_EMPTY, R_HOLD} rd_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) return v + 8'd1;
        return v;
    endfunction

    function automatic logic signed [U_WIDTH-1:0] smax(
        input logic signed [U_WIDTH-1:0] a,
        input logic signed [U_WIDTH-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    // Collector state
    coll_state_t                 r_cstate;
    coll_state_t                 w_cstate_nxt;
    logic [WIN_WIDTH-1:0]        r_win_len_q;
    logic [WIN_WIDTH-1:0]        r_win_cnt;
    logic [7:0]                  r_spike_cnt;
    logic signed [U_WIDTH-1:0]   r_peak;
    logic [7:0]                  r_last_isi;
    logic [7:0]                  r_isi_dist;
    logic                        r_isi_seen;
    logic [6:0]                  r_win_idx;
    logic                        w_win_end;

    // Holding buffer
    logic [7:0]                  r_hold_cnt;
    logic [7:0]                  r_hold_isi;
    logic signed [U_WIDTH-1:0]   r_hold_peak;
    logic [6:0]                  r_hold_idx;

    // Readout state
    rd_state_t                   r_rstate;
    rd_state_t                   w_rstate_nxt;
    logic [1:0]                  r_sel;
    logic [1:0]                  w_sel_nxt;
    logic                        r_overrun;
    logic                        w_overrun_nxt;

    // Statistics including the current cycle's sample; the window-end cycle
    // is part of its own window, so these are what gets snapshotted.
    logic [7:0]                  w_cnt_acc;
    logic signed [U_WIDTH-1:0]   w_peak_acc;
    logic [7:0]                  w_isi_acc;
    logic [7:0]                  w_dist_nxt;
    logic [7:0]                  w_peak_ext;

    assign w_cnt_acc  = sat_inc8(r_spike_cnt, bus.spike);
    assign w_peak_acc = smax(r_peak, bus.u_in);
    // A spike only closes an interval if an earlier spike exists since RUN entry.
    assign w_isi_acc  = (bus.spike && r_isi_seen) ? r_isi_dist : r_last_isi;
    // r_isi_dist is the interval a spike would close in the current cycle.
    assign w_dist_nxt = bus.spike ? 8'd1 : sat_inc8(r_isi_dist, 1'b1);
    assign w_peak_ext = {{(8-U_WIDTH){r_hold_peak[U_WIDTH-1]}}, r_hold_peak};

    // ---- collector next state ----
    always_comb begin
        w_cstate_nxt = r_cstate;
        w_win_end    = 1'b0;
        case (r_cstate)
            C_IDLE: begin
                if (bus.enable) w_cstate_nxt = C_RUN;
            end
            C_RUN: begin
                if (!bus.enable)                     w_cstate_nxt = C_IDLE;
                else if (r_win_cnt == r_win_len_q)   w_win_end    = 1'b1;
            end
            default: w_cstate_nxt = C_IDLE;
        endcase
    end

    // ---- collector registers and holding buffer ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cstate    <= C_IDLE;
            r_win_len_q <= '0;
            r_win_cnt   <= '0;
            r_spike_cnt <= '0;
            r_peak      <= PEAK_MIN;
            r_last_isi  <= '0;
            r_isi_dist  <= '0;
            r_isi_seen  <= 1'b0;
            r_win_idx   <= '0;
            r_hold_cnt  <= '0;
            r_hold_isi  <= '0;
            r_hold_peak <= '0;
            r_hold_idx  <= '0;
        end else begin
            r_cstate <= w_cstate_nxt;
            if (r_cstate == C_IDLE) begin
                r_win_cnt   <= '0;
                r_spike_cnt <= '0;
                r_peak      <= PEAK_MIN;
                r_last_isi  <= '0;
                r_isi_dist  <= '0;
                r_isi_seen  <= 1'b0;
                if (bus.enable) r_win_len_q <= bus.win_len;
            end else if (bus.enable) begin
                // ISI tracker spans window boundaries.
                r_isi_dist <= w_dist_nxt;
                r_isi_seen <= r_isi_seen | bus.spike;
                if (w_win_end) begin
                    r_hold_cnt  <= w_cnt_acc;
                    r_hold_isi  <= w_isi_acc;
                    r_hold_peak <= w_peak_acc;
                    r_hold_idx  <= r_win_idx;
                    r_win_idx   <= r_win_idx + 7'd1;
                    r_win_cnt   <= '0;
                    r_spike_cnt <= '0;
                    r_peak      <= PEAK_MIN;
                    r_last_isi  <= '0;
                end else begin
                    r_win_cnt   <= r_win_cnt + WIN_WIDTH'(1);
                    r_spike_cnt <= w_cnt_acc;
                    r_peak      <= w_peak_acc;
                    r_last_isi  <= w_isi_acc;
                end
            end
        end
    end

    // ---- readout next state ----
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_sel_nxt     = r_sel;
        w_overrun_nxt = r_overrun;
        if (w_win_end) begin
            // A new snapshot always wins, even against a same-cycle rd_next.
            w_rstate_nxt  = R_HOLD;
            w_sel_nxt     = 2'd0;
            w_overrun_nxt = r_overrun | (r_rstate == R_HOLD);
        end else if (bus.rd_next && (r_rstate == R_HOLD)) begin
            if (r_sel == 2'd3) begin
                w_rstate_nxt  = R_EMPTY;
                w_sel_nxt     = 2'd0;
                w_overrun_nxt = 1'b0;
            end else begin
                w_sel_nxt = r_sel + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate  <= R_EMPTY;
            r_sel     <= 2'd0;
            r_overrun <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_sel     <= w_sel_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // ---- byte mux ----
    always_comb begin
        bus.out_byte = 8'h00;
        if (r_rstate == R_HOLD) begin
            case (r_sel)
                2'd0:    bus.out_byte = r_hold_cnt;
                2'd1:    bus.out_byte = r_hold_isi;
                2'd2:    bus.out_byte = w_peak_ext;
                default: bus.out_byte = {r_overrun, r_hold_idx};
            endcase
        end
    end

    assign bus.out_valid = (r_rstate == R_HOLD);
    assign bus.out_sel   = r_sel;
endmodule

// File: tb/tb_spike_window_monitor.sv
module tb_spike_window_monitor;
    localparam int UW = 6;
    localparam int WW = 8;

    logic clk;
    logic reset;

    spike_window_monitor_if #(.U_WIDTH(UW), .WIN_WIDTH(WW)) bus ();

    spike_window_monitor #(.U_WIDTH(UW), .WIN_WIDTH(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    bit m_run;
    int m_wlen;
    int m_t;
    int m_prev;
    int q_sp[$];
    int q_u[$];
    int q_d[$];
    bit m_valid;
    int m_sel;
    bit m_ovr;
    int m_b[3];
    int m_idx;
    int m_hidx;

    task automatic model_reset();
        m_run = 0; m_wlen = 0; m_t = 0; m_prev = -1;
        q_sp.delete(); q_u.delete(); q_d.delete();
        m_valid = 0; m_sel = 0; m_ovr = 0; m_idx = 0; m_hidx = 0;
        m_b[0] = 0; m_b[1] = 0; m_b[2] = 0;
    endtask

    task automatic model_edge(input bit en, input bit sp, input int u, input int wl, input bit rd);
        bit snap = 0;
        int cnt = 0;
        int pk = -(1 << (UW - 1));
        int isi = 0;
        int d;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_wlen = wl; m_t = 0; m_prev = -1;
                q_sp.delete(); q_u.delete(); q_d.delete();
            end
        end else if (!en) begin
            m_run = 0;
            q_sp.delete(); q_u.delete(); q_d.delete();
        end else begin
            d = 0;
            if (sp && m_prev >= 0) d = (m_t - m_prev > 255) ? 255 : m_t - m_prev;
            q_sp.push_back(int'(sp)); q_u.push_back(u); q_d.push_back(d);
            if (sp) m_prev = m_t;
            m_t++;
            if (q_sp.size() == m_wlen + 1) begin
                foreach (q_sp[i]) begin
                    cnt += q_sp[i];
                    if (q_u[i] > pk) pk = q_u[i];
                    if (q_d[i] != 0) isi = q_d[i];
                end
                if (cnt > 255) cnt = 255;
                snap = 1;
                q_sp.delete(); q_u.delete(); q_d.delete();
            end
        end
        if (snap) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1; m_sel = 0;
            m_b[0] = cnt; m_b[1] = isi; m_b[2] = pk & 255;
            m_hidx = m_idx;
            m_idx = (m_idx + 1) % 128;
        end else if (rd && m_valid) begin
            if (m_sel == 3) begin
                m_valid = 0; m_sel = 0; m_ovr = 0;
            end else begin
                m_sel++;
            end
        end
    endtask

    function automatic int model_byte();
        if (!m_valid) return 0;
        if (m_sel == 3) return (int'(m_ovr) << 7) | m_hidx;
        return m_b[m_sel];
    endfunction

    // ---------------- stimulus ----------------
    // Called at a falling edge; drives inputs, steps the model at the rising
    // edge and returns at the next falling edge with outputs settled.
    task automatic cyc(input bit en, input bit sp, input int u, input bit rd);
        bus.enable  = en;
        bus.spike   = sp;
        bus.u_in    = UW'(u);
        bus.rd_next = rd;
        @(posedge clk);
        model_edge(en, sp, u, int'(bus.win_len), rd);
        @(negedge clk);
        bus.rd_next = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.spike   = 1'b0;
        bus.rd_next = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_byte !== 8'h00) begin
            $display("FAIL reset_outputs: got valid=%0b sel=%0d byte=%02h, want 0/0/00",
                     bus.out_valid, bus.out_sel, bus.out_byte);
        end else n_pass++;
        reset = 1'b0;
        model_reset();
        repeat (3) cyc(0, 0, 0, 1);
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00) begin
            $display("FAIL reset_idle_rd: got valid=%0b byte=%02h, want 0/00", bus.out_valid, bus.out_byte);
        end else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] exp[4] = '{8'h03, 8'h04, 8'h07, 8'h00};
        do_reset();
        bus.win_len = 8'd9;
        cyc(1, 0, 0, 0);
        for (int t = 0; t < 10; t++) begin
            cyc(1, (t == 2 || t == 5 || t == 9), (t == 4) ? 7 : int'($urandom_range(0, 12)) - 6, 0);
        end
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k) || bus.out_byte !== exp[k]) begin
                $display("FAIL basic_b%0d: got valid=%0b sel=%0d byte=%02h, want 1/%0d/%02h",
                         k, bus.out_valid, bus.out_sel, bus.out_byte, k, exp[k]);
            end else n_pass++;
            cyc(0, 0, 0, 1);
        end
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00) begin
            $display("FAIL basic_empty: got valid=%0b byte=%02h, want 0/00", bus.out_valid, bus.out_byte);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        int bad = 0;
        do_reset();
        bus.win_len = 8'd9;
        cyc(1, 0, 0, 0);
        for (int t = 0; t < 10; t++) cyc(1, (t == 3), 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2) begin
            $display("FAIL areset_pre: got valid=%0b sel=%0d, want 1/2", bus.out_valid, bus.out_sel);
        end else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_byte !== 8'h00) begin
            $display("FAIL areset_immediate: got valid=%0b sel=%0d byte=%02h, want 0/0/00",
                     bus.out_valid, bus.out_sel, bus.out_byte);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 3, (i % 3) == 0);
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) begin
            $display("FAIL areset_quiet: got %0d cycles with out_valid=1, want 0", bad);
        end else n_pass++;
    endtask

    task automatic test_negative_peak();
        logic [7:0] exp[4] = '{8'h00, 8'h00, 8'hFB, 8'h00};
        do_reset();
        bus.win_len = 8'd9;
        cyc(1, 0, 0, 0);
        for (int t = 0; t < 10; t++) cyc(1, 0, -5, 0);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k) || bus.out_byte !== exp[k]) begin
                $display("FAIL negpeak_b%0d: got valid=%0b sel=%0d byte=%02h, want 1/%0d/%02h",
                         k, bus.out_valid, bus.out_sel, bus.out_byte, k, exp[k]);
            end else n_pass++;
            cyc(0, 0, 0, 1);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp1[4] = '{8'hFF, 8'h01, 8'h00, 8'h00};
        logic [7:0] exp2[4] = '{8'hFF, 8'h01, 8'h00, 8'h01};
        do_reset();
        bus.win_len = 8'd255;
        cyc(1, 1, 0, 0);
        repeat (256) cyc(1, 1, 0, 0);
        // Read the first report while the second window runs.
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k) || bus.out_byte !== exp1[k]) begin
                $display("FAIL sat_w0_b%0d: got valid=%0b sel=%0d byte=%02h, want 1/%0d/%02h",
                         k, bus.out_valid, bus.out_sel, bus.out_byte, k, exp1[k]);
            end else n_pass++;
            cyc(1, 1, 0, 1);
        end
        n_total++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL sat_between: got valid=%0b, want 0", bus.out_valid);
        end else n_pass++;
        repeat (252) cyc(1, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k) || bus.out_byte !== exp2[k]) begin
                $display("FAIL sat_w1_b%0d: got valid=%0b sel=%0d byte=%02h, want 1/%0d/%02h",
                         k, bus.out_valid, bus.out_sel, bus.out_byte, k, exp2[k]);
            end else n_pass++;
            cyc(0, 0, 0, 1);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        bus.win_len = 8'd3;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 3, 0); cyc(1, 1, 3, 0); cyc(1, 0, 3, 0); cyc(1, 0, 3, 0);
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h02) begin
            $display("FAIL ovr_first: got valid=%0b byte=%02h, want 1/02", bus.out_valid, bus.out_byte);
        end else n_pass++;
        cyc(1, 0, -1, 1);
        n_total++;
        if (bus.out_sel !== 2'd1 || bus.out_byte !== 8'h01) begin
            $display("FAIL ovr_sel1: got sel=%0d byte=%02h, want 1/01", bus.out_sel, bus.out_byte);
        end else n_pass++;
        repeat (3) cyc(1, 0, -1, 0);
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_byte !== 8'h00) begin
            $display("FAIL ovr_overwrite: got valid=%0b sel=%0d byte=%02h, want 1/0/00",
                     bus.out_valid, bus.out_sel, bus.out_byte);
        end else n_pass++;
        repeat (3) cyc(0, 0, 0, 1);
        n_total++;
        if (bus.out_sel !== 2'd3 || bus.out_byte !== 8'h81) begin
            $display("FAIL ovr_status: got sel=%0d byte=%02h, want 3/81", bus.out_sel, bus.out_byte);
        end else n_pass++;
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1);
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3 || bus.out_byte !== 8'h02) begin
            $display("FAIL ovr_cleared: got valid=%0b sel=%0d byte=%02h, want 1/3/02",
                     bus.out_valid, bus.out_sel, bus.out_byte);
        end else n_pass++;
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_abort();
        logic [7:0] exp[4] = '{8'h02, 8'h02, 8'h02, 8'h00};
        int bad = 0;
        do_reset();
        bus.win_len = 8'd9;
        cyc(1, 0, 0, 0);
        for (int t = 0; t < 4; t++) cyc(1, 1, 5, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) begin
            $display("FAIL abort_nosnap: got %0d cycles with out_valid=1, want 0", bad);
        end else n_pass++;
        cyc(1, 0, 0, 0);
        for (int t = 0; t < 10; t++) cyc(1, (t == 1 || t == 3), (t == 6) ? 2 : -3, 0);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k) || bus.out_byte !== exp[k]) begin
                $display("FAIL abort_b%0d: got valid=%0b sel=%0d byte=%02h, want 1/%0d/%02h",
                         k, bus.out_valid, bus.out_sel, bus.out_byte, k, exp[k]);
            end else n_pass++;
            cyc(0, 0, 0, 1);
        end
    endtask

    task automatic test_random();
        bit en, sp, rd;
        int u;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.win_len = WW'($urandom_range(0, 6));
            en = ($urandom_range(0, 19) != 0);
            sp = ($urandom_range(0, 2) == 0);
            u  = int'($urandom_range(0, 63)) - 32;
            rd = ($urandom_range(0, 3) == 0);
            cyc(en, sp, u, rd);
            n_total++;
            if (bus.out_valid !== 1'(m_valid) || bus.out_sel !== 2'(m_sel) ||
                bus.out_byte !== 8'(model_byte())) begin
                $display("FAIL random_c%0d: got valid=%0b sel=%0d byte=%02h, want %0b/%0d/%02h",
                         i, bus.out_valid, bus.out_sel, bus.out_byte, m_valid, m_sel, model_byte());
            end else n_pass++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.spike   = 1'b0;
        bus.u_in    = '0;
        bus.win_len = '0;
        bus.rd_next = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_async_reset();
        test_negative_peak();
        test_saturation();
        test_overrun();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spike_window_monitor.md
Name: spike_window_monitor

Overview:
- Downstream consumer of the LIF neuron stage.
- Takes the neuron's per-cycle spike bit and signed membrane potential, and accumulates statistics over a programmable window: spike count, last inter-spike interval, and peak membrane value.
- Snapshots the statistics into a holding buffer and serves them as a 4-byte report through a pulse-driven byte readout, intended for the 8-bit output pins.

Parameters:
- U_WIDTH, 6, width of membrane potential input (signed two's complement; neuron output precision).
- WIN_WIDTH, 8, width of window-length configuration.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run statistics collection when high.
- spike  input  1  neuron spike, sampled every cycle.
- u_in  input  U_WIDTH  neuron membrane potential, signed.
- win_len  input  WIN_WIDTH  window spans win_len+1 cycles; sampled only on entry to RUN.
- rd_next  input  1  single-cycle pulse: consumer has taken current byte.
- out_valid  output  1  a report is held and readable.
- out_sel  output  2  index of byte on out_byte (0..3).
- out_byte  output  8  selected report byte.

Behaviour:
- Reset (async): collector goes to IDLE; readout goes to EMPTY. Outputs on reset: out_valid=0, out_sel=0, out_byte=0x00. Window index=0, overrun=0, all counters 0.
- Collector FSM, IDLE/RUN:
  - IDLE: counters held cleared. enable=1 moves to RUN next edge and latches win_len into win_len_q.
  - RUN: every cycle with enable=1, win_cnt increments.
    - spike_cnt += spike, 8-bit, saturating at 255.
    - peak = signed max(peak, u_in). peak starts at the most negative value (-2^(U_WIDTH-1)) each window.
    - The ISI tracker counts cycles since the last spike, saturating at 255. On spike: if a previous spike was seen since RUN entry, last_isi <= distance in cycles, so back-to-back spikes give 1. The tracker then restarts.
    - The tracker persists across windows. last_isi is cleared to 0 at each window start, so it is 0 if no interval completed within the window.
  - Window end: the cycle in which win_cnt==win_len_q is included in the statistics. On that edge the values are snapshotted into holding registers together with win_idx. Counters then clear and the next window starts on the following cycle with no gap. win_idx (7-bit) increments, wrapping 127->0.
  - enable=0 in RUN returns to IDLE next edge and discards the partial window. Holding registers and readout are unaffected.
- Readout FSM, EMPTY/HOLD:
  - A snapshot sets out_valid=1 and out_sel=0.
  - Byte map:
    - sel0 = spike count.
    - sel1 = last_isi.
    - sel2 = peak sign-extended to 8 bits.
    - sel3 = {overrun, win_idx[6:0]} of the held window.
  - In EMPTY, out_byte=0x00.
  - rd_next with out_valid=1 advances out_sel by 1. rd_next at sel3 returns to EMPTY (out_valid=0, out_sel=0) and clears overrun.
  - rd_next with out_valid=0 is ignored.
  - Snapshot while out_valid=1 sets sticky overrun, overwrites the held report, and forces out_sel=0. A snapshot coincident with rd_next also counts as overrun; the snapshot wins.
- Latency: report visible on out_byte the cycle after the window-end edge. out_byte is combinational from holding registers and out_sel.

Test Plan:
- Async reset asserted mid-readout at sel2 -> out_valid=0, out_sel=0, out_byte=0x00 immediately, before the next clock edge; no report emerges afterwards without a new window.
- win_len=9, enable held, spikes at window cycles 2,5,9, u_in max +7 -> after cycle 9 edge: bytes 0x03, 0x04, 0x07, 0x00 over four rd_next pulses; then out_valid=0.
- win_len=9, no spikes, u_in constant -5 -> bytes 0x00, 0x00, 0xFB, 0x00.
- win_len=255, spike=1 every cycle -> count 0x FF (saturated), isi 0x01. Second window reports isi 0x01 at byte1 (tracker persists across windows).
- Two windows of win_len=3 complete without any rd_next -> held report status byte 0x81 (overrun, idx 1). After reading it, next window's status byte is 0x02.
- enable dropped at window cycle 4 of win_len=9, re-raised later -> no snapshot, out_valid stays 0. The next full window reports idx 0 with fresh counts.
